// File: rtl/fifo_wr_arbiter_if.sv
// Shared FIFO write-port bus between the producers/FIFO side and the arbiter.
// The master side drives requests, packet marks, data and the FIFO full flag;
// the slave side (the arbiter) returns grants and the FIFO write strobe/data.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       last;
  logic [NREQ*WIDTH-1:0] data;
  logic                  fifo_full;
  logic [NREQ-1:0]       gnt;
  logic                  fifo_write;
  logic [WIDTH-1:0]      fifo_data_in;

  modport master (
    output req, last, data, fifo_full,
    input  gnt, fifo_write, fifo_data_in
  );

  modport slave (
    input  req, last, data, fifo_full,
    output gnt, fifo_write, fifo_data_in
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// A producer that starts a multi-beat packet keeps the port until it sends
// the beat marked last; idle owners inside a packet create bubbles rather
// than letting anyone else in. Grants are combinational, so a beat moves on
// the same rising edge as its handshake.
module fifo_wr_arbiter #(
  parameter  int WIDTH = 16,
  parameter  int NREQ  = 4,
  localparam int IW    = $clog2(NREQ)
) (
  input  logic                pclk,
  input  logic                prst,
  fifo_wr_arbiter_if.slave    bus,
  output logic [IW-1:0]       owner,
  output logic                locked,
  output logic [15:0]         wr_count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [15:0]     wr_count_q, wr_count_d;

  logic            win_valid;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic [NREQ-1:0] gnt_c;
  logic [WIDTH-1:0] masked_data [NREQ];
  logic [WIDTH-1:0] data_mux;

  // Successor index in the ring; NREQ need not be a power of two.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    if (i == IW'(NREQ - 1)) begin
      return '0;
    end
    return i + 1'b1;
  endfunction

  // Pick the winner: the owner while locked, else first requester from ptr.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = ptr_q;
    if (!bus.fifo_full) begin
      if (state_q == ST_LOCK) begin
        win_valid = bus.req[owner_q];
        win_idx   = owner_q;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          if (!win_valid && bus.req[cand]) begin
            win_valid = 1'b1;
            win_idx   = cand;
          end
          cand = next_idx(cand);
        end
      end
    end
  end

  // Expand the winner into a one-hot grant vector.
  always_comb begin
    gnt_c = '0;
    if (win_valid) begin
      gnt_c[win_idx] = 1'b1;
    end
  end

  // Per-producer data gated by its grant; at most one term is non-zero.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
      assign masked_data[gi] = gnt_c[gi] ? bus.data[gi*WIDTH +: WIDTH] : '0;
    end
  endgenerate

  // OR the gated terms together to form the FIFO write data.
  always_comb begin
    data_mux = '0;
    for (int k = 0; k < NREQ; k++) begin
      data_mux = data_mux | masked_data[k];
    end
  end

  // Next-state: packet lock, rotation pointer, owner and beat counter.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    wr_count_d = wr_count_q;
    if (win_valid) begin
      wr_count_d = wr_count_q + 16'd1;
      if (state_q == ST_IDLE) begin
        owner_d = win_idx;
        ptr_d   = next_idx(win_idx);
        if (!bus.last[win_idx]) begin
          state_d = ST_LOCK;
        end
      end else if (bus.last[owner_q]) begin
        state_d = ST_IDLE;
        ptr_d   = next_idx(owner_q);
      end
    end
  end

  // State registers; asynchronous reset discards any open packet.
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign bus.gnt          = gnt_c;
  assign bus.fifo_write   = |gnt_c;
  assign bus.fifo_data_in = data_mux;
  assign owner            = owner_q;
  assign locked           = (state_q == ST_LOCK);
  assign wr_count         = wr_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios followed by a
// randomized phase, all compared against a behavioural reference model.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic          pclk = 1'b0;
  logic          prst;
  logic [1:0]    owner;
  logic          locked;
  logic [15:0]   wr_count;

  fifo_wr_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

  fifo_wr_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .pclk     (pclk),
    .prst     (prst),
    .bus      (bus),
    .owner    (owner),
    .locked   (locked),
    .wr_count (wr_count)
  );

  always #5 pclk = ~pclk;

  int errors = 0;
  int checks = 0;

  // Reference model state, plain integers
  int m_ptr, m_owner, m_count;
  bit m_locked;
  int last_w;
  logic [N-1:0] seen_gnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_ptr = 0; m_owner = 0; m_count = 0; m_locked = 1'b0; last_w = -1;
  endfunction

  // Which producer transfers this cycle, -1 for none
  function automatic int model_winner();
    if (bus.fifo_full) return -1;
    if (m_locked) return bus.req[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (bus.req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic void model_update(input int w);
    if (w < 0) return;
    m_count = (m_count + 1) % 65536;
    if (!m_locked) begin
      m_owner  = w;
      m_ptr    = (w + 1) % N;
      m_locked = !bus.last[w];
    end else if (bus.last[w]) begin
      m_locked = 1'b0;
      m_ptr    = (w + 1) % N;
    end
  endfunction

  // One clock: check combinational outputs at negedge, registers after posedge
  task automatic cycle(input bit do_check);
    int w;
    logic [N-1:0] eg;
    logic [W-1:0] ed;
    @(negedge pclk);
    w  = model_winner();
    eg = '0;
    ed = '0;
    if (w >= 0) begin
      eg[w] = 1'b1;
      ed    = bus.data[w*W +: W];
    end
    seen_gnt = bus.gnt;
    if (do_check) begin
      check("gnt", 32'(bus.gnt), 32'(eg));
      check("fifo_write", 32'(bus.fifo_write), 32'(w >= 0));
      check("fifo_data_in", 32'(bus.fifo_data_in), 32'(ed));
    end
    @(posedge pclk);
    model_update(w);
    last_w = w;
    #1;
    if (do_check) begin
      check("owner", 32'(owner), 32'(m_owner));
      check("locked", 32'(locked), 32'(m_locked));
      check("wr_count", 32'(wr_count), 32'(m_count));
      if (w >= 0)
        $display("txn t=%0t prod=%0d data=%h locked=%0d wr_count=%0d", $time, w, ed, m_locked, m_count);
    end
  endtask

  // Asynchronous reset pulse in the middle of a clock period
  task automatic do_reset();
    logic [N-1:0] eg;
    int w;
    #1 prst = 1'b0;
    model_reset();
    #1;
    w  = model_winner();
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    check("rst_gnt", 32'(bus.gnt), 32'(eg));
    #1 prst = 1'b1;
  endtask

  task automatic new_beat(input int i);
    bus.data[i*W +: W] = W'($urandom);
  endtask

  initial begin
    prst = 1'b0;
    bus.req = '0; bus.last = '0; bus.data = '0; bus.fifo_full = 1'b0;
    model_reset();
    repeat (2) @(posedge pclk);
    #1;
    check("init_locked", 32'(locked), 32'd0);
    check("init_owner", 32'(owner), 32'd0);
    check("init_wr_count", 32'(wr_count), 32'd0);
    check("init_gnt", 32'(bus.gnt), 32'd0);
    prst = 1'b1;

    // Round robin across all four single-beat producers
    for (int i = 0; i < N; i++) new_beat(i);
    bus.req = 4'b1111; bus.last = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1);
      check("rr_order", 32'(seen_gnt), 32'(4'b0001 << (k % 4)));
      new_beat(last_w);
    end
    check("rr_count", 32'(wr_count), 32'd8);

    // Full stall: one beat, three stalled cycles, then rotation resumes
    bus.req = 4'b0110; bus.last = 4'b0110;
    cycle(1'b1);
    check("stall_first", 32'(seen_gnt), 32'(4'b0010));
    new_beat(last_w);
    bus.fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1);
      check("stall_count", 32'(wr_count), 32'd9);
    end
    bus.fifo_full = 1'b0;
    cycle(1'b1);
    check("stall_release", 32'(seen_gnt), 32'(4'b0100));

    // Packet lock: producer 1 sends three beats while producer 2 waits
    bus.req = 4'b0110; bus.last = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) bus.last = 4'b0110;
      cycle(1'b1);
      check("pkt_gnt", 32'(seen_gnt), 32'(4'b0010));
      check("pkt_locked", 32'(locked), 32'(k < 2));
      new_beat(1);
    end
    bus.req = 4'b0100;
    cycle(1'b1);
    check("pkt_next", 32'(seen_gnt), 32'(4'b0100));
    check("pkt_unlocked", 32'(locked), 32'd0);

    // Bubble: producer 3 opens a packet, then goes quiet while others ask
    bus.req = 4'b1000; bus.last = 4'b0000;
    cycle(1'b1);
    check("bub_open", 32'(locked), 32'd1);
    bus.req = 4'b0111; bus.last = 4'b0111;
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1);
      check("bub_gnt", 32'(seen_gnt), 32'd0);
      check("bub_locked", 32'(locked), 32'd1);
    end
    do_reset();
    bus.req = 4'b1110; bus.last = 4'b1111;
    cycle(1'b1);
    check("post_rst_first", 32'(seen_gnt), 32'(4'b0010));

    // Randomized phase honouring the hold-until-granted rule
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if (bus.req[i] && last_w == i) begin
          bus.req[i] = ($urandom_range(0, 3) != 0);
          bus.last[i] = ($urandom_range(0, 2) == 0);
          new_beat(i);
        end else if (!bus.req[i] && $urandom_range(0, 2) == 0) begin
          bus.req[i] = 1'b1;
          bus.last[i] = ($urandom_range(0, 2) == 0);
          new_beat(i);
        end
      end
      bus.fifo_full = ($urandom_range(0, 4) == 0);
      cycle(1'b1);
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    // Counter wrap: sole single-beat requester runs the count around
    bus.fifo_full = 1'b0;
    do_reset();
    bus.req = 4'b0001; bus.last = 4'b0001;
    while (m_count != 65535) cycle(1'b0);
    check("wrap_ffff", 32'(wr_count), 32'h0000_ffff);
    cycle(1'b1);
    check("wrap_zero", 32'(wr_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one FIFO write port (fifo_write / fifo_data_in / fifo_full) among NREQ producers. It supports single-beat and multi-beat packet transfers: once a producer starts a packet, it keeps the port until it sends the beat marked last. The block sits between the producer blocks and the FIFO write side. It holds the round-robin pointer, the packet-lock state machine and a running write counter.

## Interface
- WIDTH, 16, data width of each producer and of the FIFO
- NREQ, 4, number of producers (2..8)
- IW, $clog2(NREQ), index width (derived, not overridden)
- pclk  input  1  clock, all state updates on rising edge
- prst  input  1  reset, asynchronous, active-low
- req  input  NREQ  per-producer write request, held until granted
- last  input  NREQ  per-producer "this beat ends the packet", qualified by req
- data  input  NREQ*WIDTH  flattened producer data, producer i at bits [i*WIDTH +: WIDTH]
- fifo_full  input  1  full flag from the FIFO
- gnt  output  NREQ  one-hot grant, combinational; a beat transfers on a rising edge where req[i] & gnt[i]
- fifo_write  output  1  FIFO write strobe, equal to |gnt
- fifo_data_in  output  WIDTH  data of the granted producer; 0 when no grant
- owner  output  IW  registered index of the last granted producer
- locked  output  1  registered, 1 while a packet is open
- wr_count  output  16  registered count of beats written, wraps modulo 2^16

## Operation
- State machine has two states: IDLE (locked=0) and LOCK (locked=1). Registers are state, ptr (IW bits, highest-priority index), owner and wr_count.
- Grant is suppressed entirely (gnt=0, fifo_write=0) whenever fifo_full=1, in either state. State, ptr and owner hold.
- IDLE arbitration:
  - Search order is ptr, ptr+1, …, wrapping modulo NREQ.
  - The first index i with req[i]=1 wins and gets gnt[i]=1.
- IDLE transfer by producer i:
  - owner <= i and ptr <= (i+1) mod NREQ.
  - If last[i]=0, state <= LOCK.
  - If last[i]=1, state stays IDLE (single beat).
- LOCK arbitration: gnt[owner] = req[owner] & !fifo_full. All other grants are 0 regardless of their requests.
- LOCK, owner deasserts req: this is a bubble. Lock is kept, no write happens, and other producers stay blocked.
- LOCK, beat with last[owner]=1: state <= IDLE and ptr <= (owner+1) mod NREQ.
- wr_count increments by 1 on every rising edge where fifo_write=1. It wraps from 0xFFFF to 0x0000.
- gnt is always one-hot or zero, never multi-hot. fifo_data_in is a pure mux selected by gnt.
- Producers must hold req and data stable until they see gnt at a rising edge. After that they present the next beat or drop req.

## Timing
- Reset (prst=0, asynchronous):
  - state=IDLE, ptr=0, owner=0, locked=0, wr_count=0.
  - gnt, fifo_write and fifo_data_in follow combinationally from IDLE with ptr=0. They are 0 while req=0 or fifo_full=1.
- Reset release: the first arbitration uses ptr=0.
- Latency: combinational request-to-grant, 0 cycles. Beat is written to the FIFO on the same rising edge as the handshake.
- Throughput: one beat per cycle while the FIFO is not full. The same producer may win on consecutive cycles only if it is locked or is the sole requester.
- fifo_full rising: the grant drops in the same cycle. The FIFO is never written while full.
- fifo_full falling: arbitration resumes in that cycle, using the held ptr/state.
- Reset mid-packet: the lock is discarded and state returns to IDLE with ptr=0. The remaining packet beats are arbitrated as new transfers.
- Simultaneous last=1 and fifo_full=1 in LOCK: no transfer happens and the lock is kept.
- ptr wrap: ptr = NREQ-1 followed by a win at NREQ-1 gives ptr = 0.

## Test plan
- Reset: drive prst=0 mid-run with random req. Required: locked=0, owner=0, wr_count=0, gnt=0 when req=0; first grant after release goes to the lowest requesting index.
- Round robin: req=4'b1111, last=4'b1111, fifo_full=0 for 8 cycles. Required: gnt order 0001, 0010, 0100, 1000, repeating; wr_count=8; fifo_data_in matches each producer's data.
- Full stall: req=4'b0110, then fifo_full=1 for 3 cycles. Required: fifo_write=0 and wr_count frozen during the stall; on release the grant goes to the next index in rotation.
- Packet lock: producer 1 sends 3 beats (last on the 3rd) while req[2]=1 throughout. Required: gnt=0010 ×3, locked=1 after the first beat, then gnt=0100 with locked=0.
- Bubble and reset mid-packet: producer 3 opens a packet, drops req for 2 cycles, then prst is pulsed. Required: no grants to others during the bubble, locked=1 held; after reset locked=0, ptr=0.
- Counter wrap: preload via 65536 single-beat writes. Required: wr_count 0xFFFF -> 0x0000.
